mtl_avalon_master: RTL and testbench

- Avalon-MM master (initiator) that drives the MTL controller's register slave from game-side logic.
- Game logic pushes write/read commands into a small FIFO; the block issues them one at a time with full waitrequest handling.
- Register read results (e.g. SPI byte at address 6, Qbert position at address 3) are returned as a single-cycle response pulse.
- Sits between the Qbert game sequencer and the MTL controller's Avalon slave port.

---
 rtl/mtl_pkg.sv | 26 ++
 rtl/mtl_cmd_fifo.sv | 55 +++++
 rtl/mtl_avalon_master.sv | 180 ++++++++++++++++++
 tb/tb_mtl_avalon_master.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtl_pkg.sv
// Shared definitions for the MTL Avalon master: register map, FSM states
// and the queued command format.
package mtl_pkg;

    localparam logic [7:0] A_XLENGTH            = 8'd0;
    localparam logic [7:0] A_XYDIAG_DEMI        = 8'd1;
    localparam logic [7:0] A_RANK1_XY_OFFSET    = 8'd2;
    localparam logic [7:0] A_QBERT_POSITION_XY0 = 8'd3;
    localparam logic [7:0] A_QBERT_POSITION_XY1 = 8'd4;
    localparam logic [7:0] A_QBERT_JUMP         = 8'd5;
    localparam logic [7:0] A_ISPI               = 8'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        RDWAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] data;
    } cmd_t;

endpackage

// File: rtl/mtl_cmd_fifo.sv
// Synchronous command FIFO for the Avalon master; DEPTH must be a power of two
// so the pointers wrap by plain overflow.
module mtl_cmd_fifo
    import mtl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    input  logic                     i_push,
    input  cmd_t                     i_data,
    input  logic                     i_pop,
    output cmd_t                     o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rp];

    always_ff @(posedge iCLK) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mtl_avalon_master.sv
// Avalon-MM master issuing queued register commands one at a time.
// Optional periodic SPI register poll enabled by defining MTL_SPI_POLL_EN.
module mtl_avalon_master
    import mtl_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         READ_LATENCY = 1,
    parameter int         POLL_PERIOD  = 33000,
    parameter logic [7:0] SPI_ADDR     = A_ISPI
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iCmd_valid,
    output logic        oCmd_ready,
    input  logic        iCmd_write,
    input  logic [7:0]  iCmd_addr,
    input  logic [31:0] iCmd_data,
    output logic        oRsp_valid,
    output logic [31:0] oRsp_data,
    output logic        oBusy,
    output logic [7:0]  oAvm_address,
    output logic        oAvm_read,
    output logic        oAvm_write,
    output logic [31:0] oAvm_writedata,
    input  logic [31:0] iAvm_readdata,
    input  logic        iAvm_waitrequest,
    output logic [7:0]  oSPI
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t         r_state;
    cmd_t           w_in_cmd;
    cmd_t           w_head;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic           w_push;
    logic           w_pop;
    logic           w_capture;
    logic           w_poll_go;
    logic           r_started;
    logic           r_rd;
    logic           r_wr;
    logic           r_is_poll;
    logic [7:0]     r_addr;
    logic [7:0]     r_lat;
    logic [31:0]    r_wdata;
    logic           r_rsp_v;
    logic [31:0]    r_rsp_d;

    // Ready stays low until the first clock after reset release.
    assign oCmd_ready = r_started && !w_full;
    assign w_push     = iCmd_valid && oCmd_ready;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_in_cmd   = '{write: iCmd_write, addr: iCmd_addr, data: iCmd_data};
    assign w_capture  = ((r_state == READ) && !iAvm_waitrequest && (READ_LATENCY == 0)) ||
                        ((r_state == RDWAIT) && (r_lat == 8'd0));

    assign oBusy          = (w_count != '0) || (r_state != IDLE);
    assign oAvm_address   = r_addr;
    assign oAvm_read      = r_rd;
    assign oAvm_write     = r_wr;
    assign oAvm_writedata = r_wdata;
    assign oRsp_valid     = r_rsp_v;
    assign oRsp_data      = r_rsp_d;

    mtl_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .iCLK    (iCLK),
        .iRST_n  (iRST_n),
        .i_push  (w_push),
        .i_data  (w_in_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) r_started <= 1'b0;
        else         r_started <= 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state   <= IDLE;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_is_poll <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lat     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_addr    <= w_head.addr;
                        r_wdata   <= w_head.data;
                        r_is_poll <= 1'b0;
                        r_wr      <= w_head.write;
                        r_rd      <= !w_head.write;
                        r_state   <= w_head.write ? WRITE : READ;
                    end else if (w_poll_go) begin
                        r_addr    <= SPI_ADDR;
                        r_is_poll <= 1'b1;
                        r_rd      <= 1'b1;
                        r_state   <= READ;
                    end
                end
                WRITE: begin
                    if (!iAvm_waitrequest) begin
                        r_wr    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                READ: begin
                    if (!iAvm_waitrequest) begin
                        r_rd <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            r_state <= IDLE;
                        end else begin
                            r_lat   <= 8'(READ_LATENCY - 1);
                            r_state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (r_lat == 8'd0) r_state <= IDLE;
                    else               r_lat   <= r_lat - 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Internal polls land in oSPI only; the response port sees game reads.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rsp_v <= 1'b0;
            r_rsp_d <= '0;
        end else begin
            r_rsp_v <= w_capture && !r_is_poll;
            if (w_capture && !r_is_poll) r_rsp_d <= iAvm_readdata;
        end
    end

`ifdef MTL_SPI_POLL_EN
    logic [15:0] r_pcnt;
    logic        r_pend;
    logic [7:0]  r_spi;

    assign w_poll_go = (r_state == IDLE) && w_empty && r_pend;
    assign oSPI      = r_spi;

    // The pending flag saturates: several elapsed periods collapse into one poll.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_pcnt <= '0;
            r_pend <= 1'b0;
            r_spi  <= '0;
        end else begin
            if (r_pcnt == 16'(POLL_PERIOD - 1)) begin
                r_pcnt <= '0;
                r_pend <= 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
                if (w_poll_go) r_pend <= 1'b0;
            end
            if (w_capture && r_is_poll) r_spi <= iAvm_readdata[7:0];
        end
    end
`else
    logic w_unused_cfg;

    assign w_poll_go    = 1'b0;
    assign oSPI         = 8'd0;
    assign w_unused_cfg = POLL_PERIOD[0];
`endif

endmodule

// File: tb/tb_mtl_avalon_master.sv
// Self-checking bench for mtl_avalon_master: Avalon slave model, bus monitor
// and an in-order command/memory reference model.
`timescale 1ns/1ps
module tb_mtl_avalon_master;
    localparam int         FIFO_DEPTH   = 4;
    localparam int         READ_LATENCY = 1;
    localparam int         POLL_PERIOD  = 10;
    localparam logic [7:0] SPI_ADDR     = 8'd6;
`ifdef MTL_SPI_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iCmd_valid = 1'b0;
    logic        oCmd_ready;
    logic        iCmd_write = 1'b0;
    logic [7:0]  iCmd_addr = '0;
    logic [31:0] iCmd_data = '0;
    logic        oRsp_valid;
    logic [31:0] oRsp_data;
    logic        oBusy;
    logic [7:0]  oAvm_address;
    logic        oAvm_read;
    logic        oAvm_write;
    logic [31:0] oAvm_writedata;
    logic [31:0] rd_reg = '0;
    logic        waitreq = 1'b0;
    logic [7:0]  oSPI;

    always #5 clk = ~clk;

    mtl_avalon_master #(
        .FIFO_DEPTH(FIFO_DEPTH), .READ_LATENCY(READ_LATENCY),
        .POLL_PERIOD(POLL_PERIOD), .SPI_ADDR(SPI_ADDR)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n),
        .iCmd_valid(iCmd_valid), .oCmd_ready(oCmd_ready), .iCmd_write(iCmd_write),
        .iCmd_addr(iCmd_addr), .iCmd_data(iCmd_data),
        .oRsp_valid(oRsp_valid), .oRsp_data(oRsp_data), .oBusy(oBusy),
        .oAvm_address(oAvm_address), .oAvm_read(oAvm_read), .oAvm_write(oAvm_write),
        .oAvm_writedata(oAvm_writedata), .iAvm_readdata(rd_reg),
        .iAvm_waitrequest(waitreq), .oSPI(oSPI)
    );

    typedef struct packed {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       bus_q[$];
    int          bus_cyc_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] mem [256];
    int tests = 0, fails = 0;
    int wr_cycles = 0, rsp_cnt = 0, proto_err = 0, cyc = 0;
    logic        p_stall = 1'b0, p_w = 1'b0;
    logic [7:0]  p_a = '0;
    logic [31:0] p_d = '0;

    // Slave model (readdata registered one cycle after acceptance) plus bus monitor.
    always @(posedge clk) begin
        xfer_t x;
        cyc++;
        if (rst_n) begin
            if (oAvm_write) wr_cycles++;
            if (oAvm_read && oAvm_write) proto_err++;
            if (p_stall && !((p_w ? oAvm_write : oAvm_read) && oAvm_address == p_a &&
                             (!p_w || oAvm_writedata == p_d))) proto_err++;
            p_stall = (oAvm_read || oAvm_write) && waitreq;
            p_w = oAvm_write; p_a = oAvm_address; p_d = oAvm_writedata;
            if ((oAvm_read || oAvm_write) && !waitreq) begin
                x.w = oAvm_write; x.a = oAvm_address; x.d = oAvm_write ? oAvm_writedata : 32'h0;
                bus_q.push_back(x);
                bus_cyc_q.push_back(cyc);
                if (oAvm_write) mem[oAvm_address] = oAvm_writedata;
                else rd_reg <= mem[oAvm_address];
            end
            if (oRsp_valid) begin
                rsp_cnt++;
                rsp_q.push_back(oRsp_data);
            end
        end else begin
            p_stall = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic clear_logs();
        bus_q.delete(); bus_cyc_q.delete(); rsp_q.delete();
        wr_cycles = 0; rsp_cnt = 0; proto_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; iCmd_valid = 1'b0; waitreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d, output bit ok);
        int t = 0;
        @(negedge clk);
        iCmd_valid = 1'b1; iCmd_write = w; iCmd_addr = a; iCmd_data = d;
        while (!oCmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = oCmd_ready;
        @(negedge clk);
        iCmd_valid = 1'b0;
    endtask

    // Skips internal SPI polls when looking for the next game command on the bus.
    function automatic int next_bus(input int idx, input xfer_t e);
        int i = idx;
        while (POLL_EN && i < bus_q.size() && !bus_q[i].w && bus_q[i].a == SPI_ADDR &&
               !(!e.w && e.a == SPI_ADDR)) i++;
        return i;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({oCmd_ready, oBusy, oAvm_read, oAvm_write, oRsp_valid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {oCmd_ready, oBusy, oAvm_read, oAvm_write, oRsp_valid});
        end
        tests++;
        if ({oAvm_address, oAvm_writedata, oRsp_data, oSPI} !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {oAvm_address, oAvm_writedata, oRsp_data, oSPI});
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (oCmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_clock: got %b expected 0", oCmd_ready);
        end
        @(negedge clk);
        tests++;
        if ({oCmd_ready, oBusy} !== 2'b10) begin
            fails++;
            $display("FAIL ready_after_release: got %b expected 10", {oCmd_ready, oBusy});
        end
    endtask

    task automatic test_write();
        bit ok;
        xfer_t e;
        do_reset(); clear_logs();
        push(1'b1, 8'd3, 32'h000A5014, ok);
        repeat (4) @(negedge clk);
        e.w = 1'b1; e.a = 8'd3; e.d = 32'h000A5014;
        tests++;
        if (!ok || wr_cycles !== 1) begin
            fails++;
            $display("FAIL write_cycles: got %0d expected 1 (accepted %0d)", wr_cycles, ok);
        end
        tests++;
        if (bus_q.size() != 1 || bus_q[0] !== e) begin
            fails++;
            $display("FAIL write_xfer: got %0d xfers first %h expected 1 xfer %h", bus_q.size(),
                     bus_q.size() > 0 ? bus_q[0] : '0, e);
        end
        tests++;
        if (rsp_cnt !== 0) begin
            fails++;
            $display("FAIL write_no_rsp: got %0d expected 0", rsp_cnt);
        end
    endtask

    task automatic test_write_wait();
        bit ok, stable;
        int t = 0;
        do_reset(); clear_logs();
        push(1'b1, 8'd3, 32'h000A5014, ok);
        while (!oAvm_write && t < 20) begin
            @(negedge clk);
            t++;
        end
        waitreq = 1'b1;
        stable = oAvm_write;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stable &= (oAvm_write === 1'b1) && (oAvm_address === 8'd3) && (oAvm_writedata === 32'h000A5014);
        end
        waitreq = 1'b0;
        @(negedge clk);
        tests++;
        if (!ok || !stable) begin
            fails++;
            $display("FAIL wait_stable: got stable=%0d accepted=%0d expected 1", stable, ok);
        end
        tests++;
        if ({oAvm_write, 32'(wr_cycles), 32'(bus_q.size())} !== {1'b0, 32'd4, 32'd1}) begin
            fails++;
            $display("FAIL wait_complete: got wr=%b cycles=%0d xfers=%0d expected 0/4/1",
                     oAvm_write, wr_cycles, bus_q.size());
        end
    endtask

    task automatic test_read();
        int n = 0;
        bit got = 0;
        do_reset(); clear_logs();
        mem[6] = 32'h000000C3;
        @(negedge clk);
        iCmd_valid = 1'b1; iCmd_write = 1'b0; iCmd_addr = 8'd6; iCmd_data = $urandom;
        tests++;
        if (oCmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL read_ready: got %b expected 1", oCmd_ready);
        end
        while (!got && n < 20) begin
            @(negedge clk);
            iCmd_valid = 1'b0;
            n++;
            if (oRsp_valid) got = 1;
        end
        tests++;
        if (!got || n != 3 + READ_LATENCY) begin
            fails++;
            $display("FAIL read_latency: got %0d cycles (seen %0d) expected %0d", n, got, 3 + READ_LATENCY);
        end
        tests++;
        if (oRsp_data !== 32'h000000C3) begin
            fails++;
            $display("FAIL read_data: got %h expected 000000c3", oRsp_data);
        end
        repeat (3) @(negedge clk);
        tests++;
        if ({oRsp_valid, oRsp_data, 32'(rsp_cnt)} !== {1'b0, 32'h000000C3, 32'd1}) begin
            fails++;
            $display("FAIL read_hold: got v=%b d=%h n=%0d expected 0/000000c3/1", oRsp_valid, oRsp_data, rsp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        xfer_t exp_q[$];
        xfer_t e;
        int t = 0, idx = 0;
        bit blocked = 1, ordered = 1;
        do_reset(); clear_logs();
        @(negedge clk);
        waitreq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e.w = 1'b1; e.a = 8'(8'h10 + i); e.d = $urandom;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            iCmd_valid = 1'b1; iCmd_write = 1'b1; iCmd_addr = exp_q[i].a; iCmd_data = exp_q[i].d;
            tests++;
            if (oCmd_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready_%0d: got %b expected 1", i, oCmd_ready);
            end
            @(negedge clk);
        end
        iCmd_addr = exp_q[5].a; iCmd_data = exp_q[5].d;
        tests++;
        if (oCmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_full: got ready %b expected 0", oCmd_ready);
        end
        repeat (3) begin
            @(negedge clk);
            if (oCmd_ready) blocked = 0;
        end
        waitreq = 1'b0;
        while (!oCmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        iCmd_valid = 1'b0;
        t = 0;
        while (oBusy && t < 100) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (!blocked || oBusy) begin
            fails++;
            $display("FAIL b2b_flow: got blocked=%0d busy=%b expected 1/0", blocked, oBusy);
        end
        foreach (exp_q[i]) begin
            idx = next_bus(idx, exp_q[i]);
            if (idx >= bus_q.size() || bus_q[idx] !== exp_q[i]) ordered = 0;
            idx++;
        end
        tests++;
        if (!ordered) begin
            fails++;
            $display("FAIL b2b_order: got %0d xfers expected 6 writes to 10..15 in order", bus_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, ok3;
        int t = 0;
        do_reset(); clear_logs();
        push(1'b1, 8'd1, 32'h11111111, ok1);
        while (!oAvm_write && t < 20) begin
            @(negedge clk);
            t++;
        end
        waitreq = 1'b1;
        push(1'b1, 8'd2, 32'h22222222, ok2);
        push(1'b0, 8'd4, 32'h0, ok3);
        @(negedge clk);
        tests++;
        if ({ok1, ok2, ok3, oAvm_write, oBusy} !== 5'b11111) begin
            fails++;
            $display("FAIL midrst_setup: got %b expected 11111", {ok1, ok2, ok3, oAvm_write, oBusy});
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({oAvm_write, oAvm_read, oBusy, oCmd_ready} !== 4'b0) begin
            fails++;
            $display("FAIL midrst_drop: got %b expected 0000", {oAvm_write, oAvm_read, oBusy, oCmd_ready});
        end
        @(negedge clk);
        clear_logs();
        waitreq = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if ({32'(bus_q.size()), 32'(rsp_cnt), oBusy, oCmd_ready} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL midrst_idle: got xfers=%0d rsp=%0d busy=%b ready=%b expected 0/0/0/1",
                     bus_q.size(), rsp_cnt, oBusy, oCmd_ready);
        end
    endtask

    task automatic test_random();
        localparam int NCMD = 60;
        logic [31:0] ref_mem [256];
        xfer_t exp_q[$];
        logic [31:0] exp_rsp[$];
        xfer_t e;
        int n = 0, guard = 0, idx = 0, bad = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem[i] = ref_mem[i];
        end
        clear_logs();
        @(negedge clk);
        while (n < NCMD && guard < 3000) begin
            waitreq = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) begin
                iCmd_valid = 1'b1;
                iCmd_write = 1'($urandom_range(0, 1));
                iCmd_addr  = 8'($urandom_range(0, 15));
                iCmd_data  = $urandom;
                if (oCmd_ready) begin
                    e.w = iCmd_write; e.a = iCmd_addr; e.d = iCmd_write ? iCmd_data : 32'h0;
                    exp_q.push_back(e);
                    if (iCmd_write) ref_mem[iCmd_addr] = iCmd_data;
                    else exp_rsp.push_back(ref_mem[iCmd_addr]);
                    n++;
                end
            end else begin
                iCmd_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        iCmd_valid = 1'b0;
        guard = 0;
        while (oBusy && guard < 2000) begin
            waitreq = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            guard++;
        end
        waitreq = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (n != NCMD || oBusy) begin
            fails++;
            $display("FAIL rand_drain: got %0d cmds busy=%b expected %0d/0", n, oBusy, NCMD);
        end
        foreach (exp_q[i]) begin
            idx = next_bus(idx, exp_q[i]);
            if (idx >= bus_q.size() || bus_q[idx] !== exp_q[i]) begin
                if (bad < 4)
                    $display("FAIL rand_xfer_%0d: got %h expected %h", i,
                             idx < bus_q.size() ? bus_q[idx] : '0, exp_q[i]);
                bad++;
            end
            idx++;
        end
        tests++;
        if (bad != 0) fails++;
        bad = 0;
        tests++;
        if (rsp_q.size() != exp_rsp.size()) begin
            fails++;
            $display("FAIL rand_rsp_count: got %0d expected %0d", rsp_q.size(), exp_rsp.size());
        end else begin
            foreach (exp_rsp[i]) begin
                if (rsp_q[i] !== exp_rsp[i]) begin
                    if (bad < 4) $display("FAIL rand_rsp_%0d: got %h expected %h", i, rsp_q[i], exp_rsp[i]);
                    bad++;
                end
            end
            if (bad != 0) fails++;
        end
        tests++;
        if (proto_err !== 0) begin
            fails++;
            $display("FAIL rand_protocol: got %0d violations expected 0", proto_err);
        end
        tests++;
        if (!POLL_EN && oSPI !== 8'h00) begin
            fails++;
            $display("FAIL spi_tied: got %h expected 00", oSPI);
        end
    endtask

`ifdef MTL_SPI_POLL_EN
    task automatic test_poll();
        bit ok;
        int polls = 0, others = 0, min_gap = 1000, t = 0;
        do_reset(); clear_logs();
        mem[6] = 32'h0000005A;
        repeat (45) @(negedge clk);
        foreach (bus_q[i]) begin
            if (!bus_q[i].w && bus_q[i].a == SPI_ADDR) polls++;
            else others++;
            if (i > 0 && bus_cyc_q[i] - bus_cyc_q[i-1] < min_gap) min_gap = bus_cyc_q[i] - bus_cyc_q[i-1];
        end
        tests++;
        if (polls < 3 || others != 0 || min_gap < POLL_PERIOD) begin
            fails++;
            $display("FAIL poll_rate: got polls=%0d others=%0d gap=%0d expected >=3/0/>=%0d",
                     polls, others, min_gap, POLL_PERIOD);
        end
        tests++;
        if ({oSPI, 32'(rsp_cnt)} !== {8'h5A, 32'd0}) begin
            fails++;
            $display("FAIL poll_spi: got spi=%h rsp=%0d expected 5a/0", oSPI, rsp_cnt);
        end
        do_reset(); clear_logs();
        push(1'b1, 8'h20, 32'hAAAA0000, ok);
        while (!oAvm_write && t < 20) begin
            @(negedge clk);
            t++;
        end
        waitreq = 1'b1;
        repeat (12) @(negedge clk);
        push(1'b1, 8'h21, 32'hBBBB0000, ok);
        waitreq = 1'b0;
        t = 0;
        while (bus_q.size() < 3 && t < 30) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (bus_q.size() < 3 || bus_q[0].a !== 8'h20 || bus_q[1].a !== 8'h21 || !bus_q[1].w ||
            bus_q[2].w || bus_q[2].a !== SPI_ADDR) begin
            fails++;
            $display("FAIL poll_priority: got %0d xfers expected write 20, write 21, read 06", bus_q.size());
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_write();
        test_write_wait();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MTL_SPI_POLL_EN
        test_poll();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
